// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side consumer stage for the async FIFO. It runs entirely in the read
// clock domain. It pops words from the FIFO head and presents them
// downstream as a registered valid/ready stream through a 2-entry skid
// buffer.
//
// rd_inc depends only on rd_empty and the buffer state. There is therefore
// no combinational path from out_ready to the FIFO pop strobe, and the
// stage still sustains one word per cycle.
//
// Parameters:
//   DSIZE   data word width (must match the FIFO's DSIZE)
//   CNT_W   width of the statistics counters (used with FIFO_RD_STATS_EN)
//
// Ports:
//   clk         read-domain clock (same net as the FIFO rd_clk)
//   rst         synchronous active-high reset (same net as the FIFO rd_rst)
//   rd_empty    FIFO empty flag; rd_data is invalid while high
//   rd_data     FIFO head word, valid whenever rd_empty = 0
//   rd_inc      pop strobe to the FIFO
//   out_valid   out_data holds a valid word
//   out_ready   downstream accepts the word this cycle
//   out_data    head word of the skid buffer, straight from a register
//   out_level   skid buffer occupancy, 0..2
//
// Optional feature, macro FIFO_RD_STATS_EN:
//   stat_clr    synchronous clear of both counters
//   stat_words  saturating count of transfers (out_valid && out_ready)
//   stat_stalls saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_empty,
    input  logic [DSIZE-1:0] rd_data,
    output logic             rd_inc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic [1:0]       out_level
`ifdef FIFO_RD_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_words,
    output logic [CNT_W-1:0] stat_stalls
`endif
);

    // Reject nonsensical widths at elaboration time.
    if (DSIZE < 1 || CNT_W < 1) begin : g_param_check
        $error("fifo_rd_stream: DSIZE and CNT_W must be at least 1");
    end

    // The state encoding equals the occupancy, so out_level is the state.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DSIZE-1:0] ent0;
    logic [DSIZE-1:0] ent1;
    logic [DSIZE-1:0] ent0_nxt;
    logic [DSIZE-1:0] ent1_nxt;
    logic             push;
    logic             pop;

    // The FIFO is popped whenever it has data and a slot is guaranteed free.
    // In ONE, a pushed word goes either to ent0 (on a simultaneous pop) or
    // to ent1, so no look at out_ready is needed.
    assign rd_inc    = !rst && !rd_empty && (state != S_TWO);
    assign push      = rd_inc;
    assign out_valid = (state != S_EMPTY);
    assign pop       = out_valid && out_ready;
    assign out_data  = ent0;
    assign out_level = state;

    always_comb begin
        state_nxt = state;
        ent0_nxt  = ent0;
        ent1_nxt  = ent1;
        unique case (state)
            S_EMPTY: begin
                if (push) begin
                    ent0_nxt  = rd_data;
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    ent0_nxt = rd_data;
                end else if (push) begin
                    ent1_nxt  = rd_data;
                    state_nxt = S_TWO;
                end else if (pop) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                // rd_inc is forced low here, so only a pop can happen.
                if (pop) begin
                    ent0_nxt  = ent1;
                    state_nxt = S_ONE;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            state <= state_nxt;
            ent0  <= ent0_nxt;
            ent1  <= ent1_nxt;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic stall;

    assign stall = out_valid && !out_ready;

    // Both counters saturate at all-ones. A clear wins over an increment
    // that lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_words  <= '0;
            stat_stalls <= '0;
        end else begin
            if (pop && (stat_words != {CNT_W{1'b1}})) begin
                stat_words <= stat_words + CNT_W'(1);
            end
            if (stall && (stat_stalls != {CNT_W{1'b1}})) begin
                stat_stalls <= stat_stalls + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer stage for the async FIFO; runs entirely in the read clock domain.
- Drives the FIFO's rd_inc from its rd_empty flag and captures rd_data, which is the combinational head-of-queue word.
- Presents the data downstream as a registered valid/ready stream through a 2-entry skid buffer.
- Sustains one word per cycle with registered out_data; rd_inc depends only on rd_empty and internal state, so there is no combinational path from out_ready.

Parameters:
- DSIZE, 8, data word width; must match the FIFO's DSIZE.
- CNT_W, 16, width of the statistics counters (used only with FIFO_RD_STATS_EN).

Ports:
- clk  input  1  read-domain clock (the same net as the FIFO's rd_clk).
- rst  input  1  reset; synchronous, active-high (the same net as the FIFO's rd_rst).
- rd_empty  input  1  FIFO empty flag; 1 means rd_data is not valid.
- rd_data  input  DSIZE  FIFO head word; valid whenever rd_empty=0.
- rd_inc  output  1  pop strobe to the FIFO; the FIFO advances its read pointer at the clk edge where rd_inc=1.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word; a transfer occurs on a clk edge with out_valid=1 and out_ready=1.
- out_data  output  DSIZE  head word of the skid buffer; driven directly from a register.
- out_level  output  2  skid buffer occupancy, 0..2.

Behaviour:
- Storage and state:
  - Two registers: ent0 is the head and drives out_data; ent1 is the overflow.
  - State machine states: EMPTY (level 0), ONE (level 1), TWO (level 2).
  - out_level encodes the state; out_valid = (state != EMPTY).
- Pop and push terms:
  - rd_inc = !rst && !rd_empty && (state != TWO). This is combinational, from rd_empty and state only.
  - push = rd_inc. pop = out_valid && out_ready.
- Transitions, evaluated at each clk edge:
  - EMPTY: on push, ent0 <= rd_data and go to ONE. With no push, stay.
  - ONE, push && pop: ent0 <= rd_data, stay in ONE.
  - ONE, push only: ent1 <= rd_data, go to TWO.
  - ONE, pop only: go to EMPTY.
  - ONE, neither: hold.
  - TWO: no push is possible. On pop, ent0 <= ent1 and go to ONE. Otherwise hold.
- Reset:
  - While rst=1: rd_inc=0. At the edge, state goes to EMPTY, so out_valid=0 and out_level=0.
  - ent0 and ent1 reset to 0, so out_data=0 after reset.
  - A reset mid-operation discards buffered words. No pop is issued to the FIFO during reset.
- Latency:
  - rd_empty=0 at edge N with state EMPTY: the word is captured at N, and out_valid=1 and out_data hold the word in cycle N+1.
- Throughput:
  - With out_ready held at 1 and the FIFO non-empty, one word per cycle and the state stays in ONE.
- Stream rules:
  - While out_valid=1 and out_ready=0, out_data and out_valid are held stable.
  - Word order is strictly the FIFO order; no word is dropped or duplicated.
- Boundary conditions:
  - rd_empty rising in the same cycle the buffer drains: no push; ONE with pop goes to EMPTY.
  - rd_empty=1: rd_inc=0 regardless of state. The block never pops an empty FIFO.
  - TWO: rd_inc=0 even if rd_empty=0; the FIFO keeps the word.
- out_ready may be asserted with out_valid=0; it has no effect.

Optional Feature:
- Macro: FIFO_RD_STATS_EN.
- With the macro defined, three extra ports exist:
  - stat_clr  input  1  synchronous clear of both counters.
  - stat_words  output  CNT_W  count of transfers (out_valid && out_ready).
  - stat_stalls  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.
- Counter rules:
  - Both counters saturate at all-ones.
  - Both reset to 0 on rst or stat_clr. stat_clr has priority over an increment in the same cycle.
- Without the macro: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset and latency: hold rst=1 for 3 cycles with rd_empty=0 -> rd_inc=0 and out_valid=0. Release rst, with rd_data=0xA5 -> rd_inc=1 in the first cycle, then out_valid=1, out_data=0xA5, out_level=1 one cycle later.
- Streaming: FIFO supplies 0x01..0x10 back-to-back, out_ready=1 -> 16 transfers on consecutive cycles, values 0x01..0x10 in order, out_level stays at 1.
- Backpressure: out_ready=0 while words 0x11, 0x22, 0x33 are available -> level goes to 2, rd_inc=0 with 0x33 kept in the FIFO, and out_data stays 0x11. Then set out_ready=1 -> outputs 0x11, 0x22, 0x33 in order.
- Empty boundary: one word 0x7E, then rd_empty=1 with out_ready toggling 1,0,1 -> exactly one transfer of 0x7E, rd_inc never asserted while rd_empty=1, out_valid drops after the transfer.
- Reset mid-operation: level=2 holding 0x44 and 0x55, assert rst for 1 cycle -> out_valid=0, out_level=0, out_data=0 in the next cycle, and neither word is ever output.
- With FIFO_RD_STATS_EN: 5 transfers plus 3 stall cycles -> stat_words=5 and stat_stalls=3. Pulse stat_clr -> both 0. With CNT_W=2 and 6 transfers -> stat_words saturates at 3.
